// File: rtl/alu_pkg.sv
// Shared ALU types and defaults for the shift-and-add multiplier.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    localparam int MUL_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle for the multiplier.
interface shift_add_multiplier_if #(parameter int WIDTH = 4);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               overflow;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, product, overflow);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, product, overflow);
endinterface

// File: rtl/shift_add_multiplier_datapath.sv
// Multiplicand/multiplier/accumulator registers with the 2*WIDTH adder and shifts.
module mul_datapath import alu_pkg::*; #(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_sum_o,
    output logic               mplier_nxt_zero_o
);
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   mplier_nxt;

    // Full-width add cannot carry out: (2^W-1)^2 < 2^(2W).
    assign acc_sum           = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_nxt        = mplier_q >> 1;
    assign acc_sum_o         = acc_sum;
    assign mplier_nxt_zero_o = (mplier_nxt == '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: FSM, iteration count and handshake.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_multiplier import alu_pkg::*; #(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_add_multiplier_if.slave   bus
);
`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int           CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               overflow_q, overflow_d;
    logic               load, step;
    logic [2*WIDTH-1:0] acc_sum;
    logic               nxt_zero;
    logic               last_iter;

    mul_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk               (clk),
        .rst               (rst),
        .load_i            (load),
        .step_i            (step),
        .a_i               (bus.a),
        .b_i               (bus.b),
        .acc_sum_o         (acc_sum),
        .mplier_nxt_zero_o (nxt_zero)
    );

    // With early exit the shifted-out multiplier reaching zero ends the run;
    // the count bound still holds since the multiplier is empty by then anyway.
    assign last_iter = (EARLY && nxt_zero) || (count_q == LAST);

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;
    assign bus.overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    count_d = '0;
                    if (EARLY && bus.b == '0) begin
                        state_d    = DONE;
                        product_d  = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (last_iter) begin
                    state_d    = DONE;
                    product_d  = acc_sum;
                    overflow_d = |acc_sum[2*WIDTH-1:WIDTH];
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier (WIDTH=4).
module tb_shift_add_multiplier;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();
    shift_add_multiplier #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        logic       ovf;
        int         hold;
        logic       pre_ready;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Edges from the accept edge until out_valid is seen; b==0 under early exit
    // completes on the accept edge itself.
    function automatic int exp_lat(input logic [3:0] bv);
        int l;
`ifdef MUL_EARLY_TERM_EN
        l = 0;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) l = i + 1;
`else
        l = WIDTH;
`endif
        return l;
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic handoff(input string nm);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid_drop"}, bus.out_valid, 0);
        chk({nm, " in_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int lat;
        chk({nm, " in_ready_pre"}, bus.in_ready, 1);
        bus.out_ready = v.pre_ready;
        bus.in_valid  = 1'b1;
        bus.a         = v.a;
        bus.b         = v.b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 4'($urandom);
        bus.b        = 4'($urandom);
        chk({nm, " in_ready_busy"}, bus.in_ready, 0);
        wait_done(lat);
        chk({nm, " latency"}, lat, exp_lat(v.b));
        chk({nm, " product"}, bus.product, v.prod);
        chk({nm, " overflow"}, bus.overflow, v.ovf);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk({nm, " held"}, {bus.out_valid, bus.product}, {1'b1, v.prod});
        end
        handoff(nm);
    endtask

    initial begin
        vec_t vt[10];
        int   lat;
        vt[0] = '{4'd3,  4'd5,  8'd15,  1'b0, 0, 1'b1};
        vt[1] = '{4'd15, 4'd15, 8'd225, 1'b1, 0, 1'b0};
        vt[2] = '{4'd9,  4'd0,  8'd0,   1'b0, 0, 1'b0};
        vt[3] = '{4'd0,  4'd13, 8'd0,   1'b0, 0, 1'b0};
        vt[4] = '{4'd6,  4'd7,  8'd42,  1'b1, 5, 1'b0};
        vt[5] = '{4'd1,  4'd1,  8'd1,   1'b0, 0, 1'b0};
        vt[6] = '{4'd15, 4'd1,  8'd15,  1'b0, 0, 1'b1};
        vt[7] = '{4'd1,  4'd8,  8'd8,   1'b0, 0, 1'b0};
        vt[8] = '{4'd5,  4'd2,  8'd10,  1'b0, 2, 1'b0};
        vt[9] = '{4'd4,  4'd4,  8'd16,  1'b1, 0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst product", bus.product, 0);
        chk("rst overflow", bus.overflow, 0);
        rst = 1'b0;
        #1;
        chk("rst_release in_ready", bus.in_ready, 1);

        for (int i = 0; i < 10; i++) run_op(vt[i], $sformatf("vec%0d", i));

        // in_valid held high with changing operands during RUN, then back-to-back
        bus.in_valid = 1'b1;
        bus.a = 4'd2;
        bus.b = 4'd11;
        @(posedge clk); #1;
        for (int k = 0; k < 20 && bus.out_valid !== 1'b1; k++) begin
            bus.a = 4'(k + 7);
            bus.b = 4'(k + 3);
            @(posedge clk); #1;
        end
        chk("hold_iv product", bus.product, 22);
        chk("hold_iv overflow", bus.overflow, 1);
        bus.a = 4'd4;
        bus.b = 4'd3;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("b2b idle_gap", {bus.out_valid, bus.in_ready}, 2'b01);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b accepted", bus.in_ready, 0);
        wait_done(lat);
        chk("b2b latency", lat, exp_lat(4'd3));
        chk("b2b product", bus.product, 12);
        chk("b2b overflow", bus.overflow, 0);
        handoff("b2b");

        // reset two cycles into RUN abandons the operation
        bus.in_valid = 1'b1;
        bus.a = 4'd15;
        bus.b = 4'd15;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst product", bus.product, 0);
        chk("midrst overflow", bus.overflow, 0);
        chk("midrst in_ready_low", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst in_ready", bus.in_ready, 1);
        run_op(vt[9], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
